// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings, latched-request payload and store-lane helpers for the
// MEM-stage data bus initiator and its load-extend datapath.
package mem_access_ctrl_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned SIZE_W2 = 2;

  localparam logic [SIZE_W2-1:0] SIZE_B = 2'b00;
  localparam logic [SIZE_W2-1:0] SIZE_H = 2'b01;
  localparam logic [SIZE_W2-1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  typedef struct packed {
    logic               wen;
    logic               uns;
    logic [SIZE_W2-1:0] size;
    logic [1:0]         addr_lo;
  } req_lat_t;

  function automatic logic addr_misaligned(input logic [SIZE_W2-1:0] size,
                                           input logic [1:0] addr_lo);
    return ((size == SIZE_H) && addr_lo[0]) ||
           ((size == SIZE_W) && (addr_lo != 2'b00));
  endfunction

  function automatic logic [WORD_W-1:0] store_replicate(input logic [WORD_W-1:0] wdata,
                                                        input logic [SIZE_W2-1:0] size);
    logic [WORD_W-1:0] lanes;
    case (size)
      SIZE_B:  lanes = {4{wdata[7:0]}};
      SIZE_H:  lanes = {2{wdata[15:0]}};
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extend.sv
// Load lane select and sign/zero extension of a raw 32-bit read word.
module load_extend
  import mem_access_ctrl_pkg::*;
(
  input  logic [WORD_W-1:0]  rdata,
  input  logic [1:0]         addr_lo,
  input  logic [SIZE_W2-1:0] size,
  input  logic               uns,
  output logic [WORD_W-1:0]  result_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    byte_c   = 8'h00;
    half_c   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    result_c = rdata;
    case (addr_lo)
      2'b00:   byte_c = rdata[7:0];
      2'b01:   byte_c = rdata[15:8];
      2'b10:   byte_c = rdata[23:16];
      default: byte_c = rdata[31:24];
    endcase
    case (size)
      SIZE_B:  result_c = uns ? {24'h000000, byte_c} : {{24{byte_c[7]}}, byte_c};
      SIZE_H:  result_c = uns ? {16'h0000, half_c} : {{16{half_c[15]}}, half_c};
      default: result_c = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store initiator on the sram-like data bus: issues requests,
// stalls the pipeline until the response returns and registers load data.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_enM,
  input  logic              mem_wenM,
  input  logic [1:0]        mem_sizeM,
  input  logic              mem_unsignedM,
  input  logic [ADDR_W-1:0] addrM,
  input  logic [DATA_W-1:0] wdataM,
  input  logic              flushM,
  input  logic              advanceM,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic [DATA_W-1:0] mem_rdataM,
  output logic              stall_mem,
  output logic              addr_errM
);

  state_e            state_q, state_d;
  logic              cancel_q, cancel_d;
  req_lat_t          lat_q, lat_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  req_lat_t          fresh_c, bus_src_c;
  logic              start_c, cancel_eff_c, capture_c, req_c, stall_c;
  logic [WORD_W-1:0] ext_c;

  load_extend u_load_extend (
    .rdata    (data_rdata),
    .addr_lo  (lat_q.addr_lo),
    .size     (lat_q.size),
    .uns      (lat_q.uns),
    .result_c (ext_c)
  );

  // Next-state, request/stall and load-capture logic
  always_comb begin
    addr_errM    = addr_misaligned(mem_sizeM, addrM[1:0]);
    start_c      = mem_enM & ~addr_errM & ~flushM;
    cancel_eff_c = cancel_q | flushM;
    fresh_c      = '{wen: mem_wenM, uns: mem_unsignedM, size: mem_sizeM, addr_lo: addrM[1:0]};
    state_d      = state_q;
    cancel_d     = cancel_q;
    lat_d        = lat_q;
    rdata_d      = rdata_q;
    capture_c    = 1'b0;
    req_c        = 1'b0;
    stall_c      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_c   = start_c;
        stall_c = start_c;
        if (start_c) begin
          lat_d   = fresh_c;
          state_d = data_addr_ok ? ST_DATA : ST_ADDR;
        end
      end
      ST_ADDR: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        if (flushM) cancel_d = 1'b1;
        if (data_addr_ok) begin
          if (data_data_ok) begin
            capture_c = 1'b1;
            state_d   = cancel_eff_c ? ST_IDLE : ST_DONE;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        stall_c = 1'b1;
        if (flushM) cancel_d = 1'b1;
        if (data_data_ok) begin
          capture_c = 1'b1;
          state_d   = cancel_eff_c ? ST_IDLE : ST_DONE;
        end
      end
      default: begin
        if (advanceM) state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_IDLE) cancel_d = 1'b0;
    // A cancelled response completes the bus handshake but never updates the result
    if (capture_c && !lat_q.wen && !cancel_eff_c) rdata_d = DATA_W'(ext_c);
  end

  // Bus fields come straight from the MEM inputs on issue, from the latches afterwards
  always_comb begin
    bus_src_c  = (state_q == ST_IDLE) ? fresh_c : lat_q;
    data_req   = rst & req_c;
    stall_mem  = rst & stall_c;
    data_wr    = rst & bus_src_c.wen;
    data_size  = rst ? bus_src_c.size : 2'b00;
    data_addr  = rst ? {addrM[ADDR_W-1:2], bus_src_c.addr_lo} : '0;
    data_wdata = rst ? DATA_W'(store_replicate(WORD_W'(wdataM), bus_src_c.size)) : '0;
    mem_rdataM = rdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cancel_q <= 1'b0;
      lat_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
      lat_q    <= lat_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a load-result scoreboard queue.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_enM, mem_wenM, mem_unsignedM, flushM, advanceM;
  logic [1:0]  mem_sizeM;
  logic [31:0] addrM, wdataM;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata, mem_rdataM;
  logic        stall_mem, addr_errM;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd  = 32'h0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_enM       (mem_enM),
    .mem_wenM      (mem_wenM),
    .mem_sizeM     (mem_sizeM),
    .mem_unsignedM (mem_unsignedM),
    .addrM         (addrM),
    .wdataM        (wdataM),
    .flushM        (flushM),
    .advanceM      (advanceM),
    .data_req      (data_req),
    .data_wr       (data_wr),
    .data_size     (data_size),
    .data_addr     (data_addr),
    .data_wdata    (data_wdata),
    .data_addr_ok  (data_addr_ok),
    .data_data_ok  (data_data_ok),
    .data_rdata    (data_rdata),
    .mem_rdataM    (mem_rdataM),
    .stall_mem     (stall_mem),
    .addr_errM     (addr_errM)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_access(input logic wen, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata);
    mem_enM = 1'b1; mem_wenM = wen; mem_sizeM = size; mem_unsignedM = uns;
    addrM = addr; wdataM = wdata; flushM = 1'b0; advanceM = 1'b0;
  endtask

  // Responder accepts on cycle aw of the access, answers dw cycles later; ends in DONE
  task automatic run_txn(input string tag, input logic wen, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int aw, input int dw,
                         input int exp_req, input int exp_stall);
    int req_n, stall_n, acc_k;
    bit accepted, done;
    logic [31:0] exp_rd;
    req_n = 0; stall_n = 0; acc_k = 0; accepted = 1'b0; done = 1'b0;
    set_access(wen, size, uns, addr, wdata);
    for (int k = 0; k < 40 && !done; k++) begin
      data_addr_ok = 1'b0; data_data_ok = 1'b0;
      #1;
      if (data_req) req_n++;
      if (stall_mem) stall_n++;
      if (data_req && k == aw) begin data_addr_ok = 1'b1; accepted = 1'b1; acc_k = k; end
      if (accepted && k == acc_k + dw) begin data_data_ok = 1'b1; data_rdata = rdata; done = 1'b1; end
      @(posedge clk); #1;
    end
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    #1;
    check({tag, "_completed"}, 32'(done), 32'd1);
    check({tag, "_req_cycles"}, 32'(req_n), 32'(exp_req));
    check({tag, "_stall_cycles"}, 32'(stall_n), 32'(exp_stall));
    check({tag, "_done_stall"}, 32'(stall_mem), 32'd0);
    if (!wen) begin
      if (exp_q.size() == 0) begin
        check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
      end else begin
        exp_rd = exp_q.pop_front();
        last_rd = exp_rd;
      end
    end
    check({tag, "_rdata"}, mem_rdataM, last_rd);
  endtask

  task automatic advance();
    advanceM = 1'b1;
    @(posedge clk); #1;
    advanceM = 1'b0; mem_enM = 1'b0;
  endtask

  initial begin
    rst = 1'b0; mem_enM = 1'b0; mem_wenM = 1'b0; mem_sizeM = 2'b00; mem_unsignedM = 1'b0;
    addrM = 32'h0; wdataM = 32'h0; flushM = 1'b0; advanceM = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rdata", mem_rdataM, 32'h0);
    check("reset_req", 32'(data_req), 32'd0);
    check("reset_stall", 32'(stall_mem), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Minimum-latency word load
    exp_q.push_back(32'hDEADBEEF);
    run_txn("lw_min", 1'b0, SIZE_W, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1, 1, 2);
    advance();

    // Byte/half lane select and extension
    exp_q.push_back(32'hFFFFFF80);
    run_txn("lb_103", 1'b0, SIZE_B, 1'b0, 32'h103, 32'h0, 32'h80FFFF7F, 0, 1, 1, 2);
    advance();
    exp_q.push_back(32'h00000080);
    run_txn("lbu_103", 1'b0, SIZE_B, 1'b1, 32'h103, 32'h0, 32'h80FFFF7F, 0, 1, 1, 2);
    advance();
    exp_q.push_back(32'hFFFF8001);
    run_txn("lh_102", 1'b0, SIZE_H, 1'b0, 32'h102, 32'h0, 32'h80010000, 0, 1, 1, 2);
    advance();

    // Stores: lane replication, result register untouched
    set_access(1'b1, SIZE_B, 1'b0, 32'h201, 32'h123456AB);
    #1;
    check("sb_wdata", data_wdata, 32'hABABABAB);
    check("sb_size", 32'(data_size), 32'd0);
    check("sb_wr", 32'(data_wr), 32'd1);
    check("sb_addr", data_addr, 32'h201);
    run_txn("sb_201", 1'b1, SIZE_B, 1'b0, 32'h201, 32'h123456AB, 32'h0, 0, 1, 1, 2);
    advance();
    set_access(1'b1, SIZE_H, 1'b0, 32'h202, 32'h123456AB);
    #1;
    check("sh_wdata", data_wdata, 32'h56AB56AB);
    run_txn("sh_202", 1'b1, SIZE_H, 1'b0, 32'h202, 32'h123456AB, 32'h0, 0, 1, 1, 2);
    advance();

    // Misaligned word load: error, no request, no stall
    set_access(1'b0, SIZE_W, 1'b0, 32'h202, 32'h0);
    #1;
    check("lw_mis_err", 32'(addr_errM), 32'd1);
    check("lw_mis_req", 32'(data_req), 32'd0);
    check("lw_mis_stall", 32'(stall_mem), 32'd0);
    @(posedge clk); #1;
    check("lw_mis_req_next", 32'(data_req), 32'd0);
    mem_enM = 1'b0;

    // Slow bus, then pipeline held in DONE by another stall source
    exp_q.push_back(32'hA5A50F0F);
    run_txn("lw_slow", 1'b0, SIZE_W, 1'b0, 32'h300, 32'h0, 32'hA5A50F0F, 3, 1, 4, 5);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("done_hold_req_%0d", i), 32'(data_req), 32'd0);
      check($sformatf("done_hold_stall_%0d", i), 32'(stall_mem), 32'd0);
      @(posedge clk); #1;
    end
    advance();

    // Flush while waiting for data: response drained and discarded
    set_access(1'b0, SIZE_W, 1'b0, 32'h400, 32'h0);
    #1;
    check("flush_issue_req", 32'(data_req), 32'd1);
    data_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b0; flushM = 1'b1; mem_enM = 1'b0;
    #1;
    check("flush_data_stall", 32'(stall_mem), 32'd1);
    @(posedge clk); #1;
    flushM = 1'b0;
    #1;
    check("flush_wait_stall", 32'(stall_mem), 32'd1);
    data_data_ok = 1'b1; data_rdata = 32'h55555555;
    @(posedge clk); #1;
    data_data_ok = 1'b0;
    #1;
    check("flush_end_stall", 32'(stall_mem), 32'd0);
    check("flush_rdata_kept", mem_rdataM, last_rd);
    set_access(1'b0, SIZE_W, 1'b0, 32'h404, 32'h0);
    #1;
    check("flush_back_idle_req", 32'(data_req), 32'd1);
    exp_q.push_back(32'h01234567);
    run_txn("lw_after_flush", 1'b0, SIZE_W, 1'b0, 32'h404, 32'h0, 32'h01234567, 0, 1, 1, 2);
    advance();

    // Asynchronous reset mid-transaction
    set_access(1'b0, SIZE_W, 1'b0, 32'h500, 32'h0);
    data_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("arst_req", 32'(data_req), 32'd0);
    check("arst_stall", 32'(stall_mem), 32'd0);
    check("arst_rdata", mem_rdataM, 32'h0);
    check("arst_addr", data_addr, 32'h0);
    check("arst_wdata", data_wdata, 32'h0);
    check("arst_size", 32'(data_size), 32'd0);
    check("arst_wr", 32'(data_wr), 32'd0);
    last_rd = 32'h0;
    mem_enM = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.push_back(32'hCAFEF00D);
    run_txn("lw_post_rst", 1'b0, SIZE_W, 1'b0, 32'h504, 32'h0, 32'hCAFEF00D, 0, 1, 1, 2);
    advance();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
